// File: rtl/schoolbook_unload.sv
`default_nettype none
// ============================================================================
//  Module   : schoolbook_unload
//  Brief    : Waits out the schoolbook multiplier latency, captures the 2N-bit
//             product and streams it LSW-first as W-bit valid/ready words.
//  Revision : 1.0 - initial release
// ============================================================================
module schoolbook_unload #(
    parameter int N   = 283,
    parameter int W   = 32,
    parameter int LAT = N + 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] c_in,
    output logic [W-1:0]   dout,
    output logic           dout_valid,
    input  logic           dout_ready,
    output logic           dout_last,
    output logic           busy
);

    localparam int NW = (2 * N + W - 1) / W;
    localparam int SW = NW * W;
    localparam int CW = $clog2(LAT + 1);
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [CW-1:0] c_wait_load = CW'(LAT - 1);
    localparam logic [IW-1:0] c_last_idx  = IW'(NW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_cnt;
    logic [IW-1:0]   r_idx;
    logic [SW-1:0]   r_shift;
    logic            w_capture;
    logic            w_handshake;
    logic            w_last_hs;

    assign w_capture   = (r_state == S_WAIT) && (r_cnt == '0);
    assign w_handshake = dout_valid && dout_ready;
    assign w_last_hs   = w_handshake && (r_idx == c_last_idx);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start)     w_next_state = S_WAIT;
            S_WAIT:  if (w_capture) w_next_state = S_SEND;
            S_SEND:  if (w_last_hs) w_next_state = S_IDLE;
            default:                w_next_state = S_IDLE;
        endcase
    end

    // Counter is loaded with LAT-1 so that it reads zero on the LAT-th edge
    // after the start edge, which is the capture edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_cnt <= c_wait_load;
        end else if (r_state == S_WAIT && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (w_capture) begin
            r_shift <= SW'(c_in);
            r_idx   <= '0;
        end else if (w_handshake) begin
            r_shift <= r_shift >> W;
            r_idx   <= w_last_hs ? '0 : r_idx + 1'b1;
        end
    end

    // The register drains to zero after the last shift, so dout reads zero
    // whenever no stream is in flight.
    assign dout       = r_shift[W-1:0];
    assign dout_valid = (r_state == S_SEND);
    assign dout_last  = (r_state == S_SEND) && (r_idx == c_last_idx);
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_schoolbook_unload.sv
`default_nettype none
// ============================================================================
//  Module   : tb_schoolbook_unload
//  Brief    : Self-checking bench for schoolbook_unload (directed word tables).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_schoolbook_unload;

    localparam int N   = 283;
    localparam int W   = 32;
    localparam int LAT = N + 2;
    localparam int NW  = 18;

    typedef struct packed {
        logic [W-1:0] word;
        logic         last;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [2*N-1:0] c_in = '0;
    logic [W-1:0]   dout;
    logic           dout_valid;
    logic           dout_ready = 1'b0;
    logic           dout_last;
    logic           busy;

    int errors = 0;
    int checks = 0;

    exp_t           exp_tbl [0:1][0:NW-1];
    logic [2*N-1:0] prod    [0:1];
    logic [W-1:0]   rx      [0:31];
    logic           rxl     [0:31];

    schoolbook_unload #(.N(N), .W(W), .LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .c_in       (c_in),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One complete run: launch, wait for the capture, then drain the stream.
    task automatic run(input int id, input int rdy_mode, input bit mid_start,
                       input bit last_start, input int abort_at);
        int           cnt;
        int           nrx;
        int           beats;
        logic [W-1:0] pd;
        logic         pl;
        bit           stalled;
        bit           done;
        bit           aborted;

        c_in = prod[id];
        dout_ready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_rise", busy, 1);
        chk("valid_low_in_wait", dout_valid, 0);

        cnt = 0;
        while (!dout_valid && cnt < 2000) begin
            start = mid_start && (cnt == 100);
            @(negedge clk);
            cnt++;
        end
        start = 1'b0;
        chk("latency", cnt, LAT);

        // Product changes after capture must not leak into the stream.
        c_in = ~prod[id];

        nrx = 0; beats = 0; stalled = 0; done = 0; aborted = 0;
        pd = '0; pl = 0;
        while (!done && beats < 2000) begin
            start = 1'b0;
            dout_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (stalled) begin
                chk("stall_valid", dout_valid, 1);
                chk("stall_dout", dout, pd);
                chk("stall_last", dout_last, pl);
            end
            if (!dout_valid) begin
                chk("valid_in_stream", dout_valid, 1);
                done = 1;
            end else if (dout_ready) begin
                if (nrx < 32) begin
                    rx[nrx]  = dout;
                    rxl[nrx] = dout_last;
                end
                nrx++;
                if (dout_last) begin
                    done = 1;
                    start = last_start;
                end
                if (abort_at >= 0 && nrx == abort_at + 1) begin
                    done = 1;
                    aborted = 1;
                end
            end
            stalled = dout_valid && !dout_ready;
            pd = dout;
            pl = dout_last;
            @(negedge clk);
            beats++;
        end
        start = 1'b0;
        dout_ready = 1'b0;

        if (aborted) begin
            rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            chk("abort_valid", dout_valid, 0);
            chk("abort_busy", busy, 0);
            chk("abort_dout", dout, 0);
            chk("abort_last", dout_last, 0);
            repeat (3) @(negedge clk);
            chk("abort_stays_idle", dout_valid, 0);
            chk("abort_words", nrx, abort_at + 1);
        end else begin
            chk("end_valid", dout_valid, 0);
            chk("end_busy", busy, 0);
            if (last_start) begin
                repeat (3) @(negedge clk);
                chk("last_start_ignored", busy, 0);
            end
            chk("word_count", nrx, NW);
            if (rdy_mode == 0) chk("beats", beats, NW);
        end

        for (int i = 0; i < NW; i++) begin
            if (i < nrx) begin
                chk($sformatf("word%0d_case%0d", i, id), rx[i], exp_tbl[id][i].word);
                chk($sformatf("last%0d_case%0d", i, id), rxl[i], exp_tbl[id][i].last);
            end
        end
    endtask

    initial begin
        // Expected word tables, hand-derived from the products.
        prod[0] = '0;
        prod[0][0] = 1'b1;
        prod[1] = '0;
        for (int i = 284; i < 2 * N; i++) prod[1][i] = 1'b1;
        prod[1][0] = 1'b1;
        for (int i = 0; i < NW; i++) begin
            exp_tbl[0][i] = '{word: 32'h0, last: (i == NW - 1)};
            exp_tbl[1][i] = '{word: 32'h0, last: (i == NW - 1)};
        end
        exp_tbl[0][0].word = 32'h0000_0001;
        exp_tbl[1][0].word = 32'h0000_0001;
        exp_tbl[1][8].word = 32'hF000_0000;
        for (int i = 9; i <= 16; i++) exp_tbl[1][i].word = 32'hFFFF_FFFF;
        exp_tbl[1][17].word = 32'h003F_FFFF;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_dout", dout, 0);
        chk("reset_valid", dout_valid, 0);
        chk("reset_last", dout_last, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_no_start", busy, 0);

        run(0, 0, 0, 0, -1);
        run(1, 0, 0, 0, -1);
        run(1, 1, 0, 0, -1);
        run(1, 0, 1, 1, -1);
        run(0, 0, 0, 0, -1);
        run(1, 1, 0, 0, 5);
        run(1, 0, 0, 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/schoolbook_unload.md
# schoolbook_unload

Result unloader placed directly downstream of the 283x283 schoolbook multiplier. Triggered when the multiplier leaves reset, it waits a fixed number of cycles for the bit-serial accumulation to finish. It then captures the full 566-bit product and streams it out as W-bit words, least-significant word first, over a valid/ready interface. This decouples the wide multiplier output from a narrow bus or FIFO.

## Interface
- N, 283: multiplier operand width; product width is 2N.
- W, 32: output word width.
- LAT, N+2 (285): cycles from the `start` sampling edge to the product capture edge.
- Derived: NW = ceil(2N/W) = 18 words. The last word carries 2N - (NW-1)·W = 22 valid bits, zero-padded in the MSBs.
- Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse, asserted in the first cycle the multiplier's own reset is deasserted.
- c_in  in  2N  multiplier product output.
- dout  out  W  current output word.
- dout_valid  out  1  dout holds a valid word.
- dout_ready  in  1  consumer accepts the word.
- dout_last  out  1  current word is word NW-1.
- busy  out  1  high in WAIT and SEND.

## Operation
- Reset (rst==0 at a clock edge): state=IDLE, dout=0, dout_valid=0, dout_last=0, busy=0, word index=0, wait counter=0, shift register cleared.
- States: IDLE, WAIT, SEND.
- IDLE: start==1 → WAIT, wait counter loaded. start==0 → stay.
- WAIT: wait counter decrements each cycle. On the LAT-th edge after the start edge, c_in is captured into a 2N-bit (padded to NW·W) register and the state moves to SEND.
- SEND:
  - dout = register bits [W-1:0]; dout_valid=1.
  - On an edge with dout_valid & dout_ready: shift the register right by W, increment the word index.
  - dout_last=1 exactly while the index = NW-1.
  - Handshake on the last word → IDLE, with dout_valid=0 and busy=0 next cycle.
- start is ignored unless the state is IDLE, including the cycle of the final handshake.
- c_in is sampled only on the capture edge. Later changes to c_in do not affect the words being streamed.
- Padding bits above 2N-1 are always 0.

## Timing
- With start sampled at edge E, the capture happens at edge E+LAT. dout_valid first rises after edge E+LAT, and word 0 is visible in that cycle.
- With dout_ready held high, one word is transferred per cycle. All NW words finish NW cycles after capture. Total start-to-last-handshake = LAT+NW edges (303 with defaults).
- Backpressure: while dout_valid=1 and dout_ready=0, dout and dout_last stay stable and dout_valid stays high.
- dout_ready while dout_valid=0 has no effect.
- Reset mid-WAIT or mid-SEND: outputs take their reset values at the next edge and the partial stream is abandoned. No word is emitted after reset.
- busy rises the cycle after the start edge and falls the cycle after the last handshake.

## Test plan
- a=1, b=1, ready held high:
  - word0=0x00000001, words 1..17=0.
  - dout_last only on word 17.
  - dout_valid rises 285 cycles after start; 18 consecutive beats.
- a=b=2^283-1:
  - word0=0x00000001, words 1..7=0, word8=0xF0000000, words 9..16=0xFFFFFFFF, word17=0x003FFFFF.
- Same operands with ready toggled randomly:
  - identical word sequence;
  - dout stable on every stalled cycle;
  - no word duplicated or skipped.
- start pulsed again during WAIT and on the final-handshake cycle:
  - both ignored, exactly 18 words emitted;
  - a start one cycle after busy falls launches a new run.
- rst driven low during SEND after word 5:
  - next cycle dout_valid=0, busy=0, dout=0;
  - a new start gives a full 18-word stream beginning at word 0.
- c_in changed after capture: streamed words match the value present at the capture edge.
